a1000_frontram_sync: RTL and testbench

Clocked, parametrised successor to the A1000 Front-RAM glue logic. Oversamples the Agnus DRAM control bus (/RAS, per-bank /CAS lanes, /RRW, multiplexed DRA) on a local clock and drives a bank of asynchronous SRAMs with registered address, chip enables, and a fixed-width write pulse. Distinguishes normal, page-mode, RAS-only refresh and CAS-before-RAS cycles, counts refreshes, and flags bus protocol violations. Sits between the motherboard DRAM socket signals and the SRAM array on the expansion board.

---
 rtl/a1000_frontram_sync.sv | 205 ++++++++++++++++++++
 tb/tb_a1000_frontram_sync.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/a1000_frontram_sync.sv
// Oversamples the Agnus DRAM control bus and drives an asynchronous SRAM bank with
// registered address, chip enables and a fixed-width write pulse; counts refreshes and flags bus errors.
module a1000_frontram_sync #(
  parameter int ROW_BITS    = 8,
  parameter int NUM_BANKS   = 2,
  parameter int WE_CYCLES   = 2,
  parameter int SYNC_STAGES = 2,
  localparam int BANK_BITS  = (NUM_BANKS == 4) ? 2 : 1,
  localparam int ADDR_W     = 2 * ROW_BITS + BANK_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ras_n,
  input  logic                 rrw_n,
  input  logic [NUM_BANKS-1:0] casl_n,
  input  logic [NUM_BANKS-1:0] casu_n,
  input  logic [ROW_BITS-1:0]  dra,
  output logic [ADDR_W-1:0]    sram_a,
  output logic                 ce2,
  output logic                 ce1_l_n,
  output logic                 ce1_u_n,
  output logic                 oe_n,
  output logic                 we_n,
  output logic [15:0]          refresh_cnt,
  output logic                 err,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_ACCESS, S_WRITE, S_WHOLD, S_REFRESH
  } state_t;

  localparam int SW = 2 + 2 * NUM_BANKS + ROW_BITS;
  localparam logic [SW-1:0] SYNC_RST = {{(2 + 2 * NUM_BANKS){1'b1}}, {ROW_BITS{1'b0}}};
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES);

  // dra rides in the same synchroniser word so it stays aligned with the strobes
  logic [SW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {ras_n, rrw_n, casl_n, casu_n, dra};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic                 ras_s, rrw_s;
  logic [NUM_BANKS-1:0] casl_s, casu_s;
  logic [ROW_BITS-1:0]  dra_s;
  assign {ras_s, rrw_s, casl_s, casu_s, dra_s} = sync_q[SYNC_STAGES-1];

  logic [NUM_BANKS-1:0] bank_act;
  logic                 cas_any, cas_multi;
  logic [BANK_BITS-1:0] bank_low;

  assign bank_act  = ~(casl_s & casu_s);
  assign cas_any   = |bank_act;
  assign cas_multi = (bank_act & (bank_act - 1'b1)) != '0;

  always_comb begin
    bank_low = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_act[b]) bank_low = BANK_BITS'(b);
    end
  end

  state_t               state_q, state_d, exit_state;
  logic                 ras_prev_q;
  logic [ROW_BITS-1:0]  row_q, row_d, a_row_q, a_row_d, col_q, col_d;
  logic [BANK_BITS-1:0] bank_q, bank_d;
  logic                 cas_seen_q, cas_seen_d;
  logic [3:0]           we_cnt_q, we_cnt_d;
  logic [15:0]          ref_q, ref_d;
  logic                 err_q, err_d;
  logic                 ce2_q, ce2_d, ce1l_q, ce1l_d, ce1u_q, ce1u_d;
  logic                 oe_q, oe_d, we_q, we_d;
  logic                 ras_fall, lanes_on;

  assign ras_fall   = ras_prev_q && !ras_s;
  assign exit_state = ras_s ? S_IDLE : S_ROW;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    a_row_d    = a_row_q;
    col_d      = col_q;
    bank_d     = bank_q;
    cas_seen_d = cas_seen_q;
    we_cnt_d   = we_cnt_q;
    ref_d      = ref_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (ras_fall) begin
          if (cas_any) begin
            state_d = S_REFRESH;
            ref_d   = ref_q + 16'd1;
          end else begin
            row_d      = dra_s;
            cas_seen_d = 1'b0;
            state_d    = S_ROW;
          end
        end
      end
      S_ROW: begin
        if (cas_any) begin
          col_d      = dra_s;
          bank_d     = bank_low;
          a_row_d    = row_q;
          cas_seen_d = 1'b1;
          we_cnt_d   = 4'd1;
          if (cas_multi) err_d = 1'b1;
          state_d = rrw_s ? S_ACCESS : S_WRITE;
        end else if (ras_s) begin
          // RAS released without any CAS in this row: RAS-only refresh
          state_d = S_IDLE;
          if (!cas_seen_q) ref_d = ref_q + 16'd1;
        end
      end
      S_ACCESS, S_WHOLD: begin
        if (!cas_any) state_d = exit_state;
      end
      S_WRITE: begin
        if (we_cnt_q == WE_LAST) begin
          state_d = cas_any ? S_WHOLD : exit_state;
        end else if (!cas_any) begin
          err_d   = 1'b1;
          state_d = exit_state;
        end else begin
          we_cnt_d = we_cnt_q + 4'd1;
        end
      end
      S_REFRESH: begin
        if (ras_s && !cas_any) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each one lands on the transition edge
  always_comb begin
    lanes_on = (state_d == S_ACCESS) || (state_d == S_WRITE) || (state_d == S_WHOLD);
    ce2_d    = lanes_on || (state_d == S_ROW);
    ce1l_d   = 1'b1;
    ce1u_d   = 1'b1;
    if (state_d == S_WHOLD) begin
      ce1l_d = ce1l_q;
      ce1u_d = ce1u_q;
    end else if (lanes_on) begin
      ce1l_d = &casl_s;
      ce1u_d = &casu_s;
    end
    oe_d = state_d != S_ACCESS;
    we_d = state_d != S_WRITE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ras_prev_q <= 1'b1;
      row_q      <= '0;
      a_row_q    <= '0;
      col_q      <= '0;
      bank_q     <= '0;
      cas_seen_q <= 1'b0;
      we_cnt_q   <= '0;
      ref_q      <= '0;
      err_q      <= 1'b0;
      ce2_q      <= 1'b0;
      ce1l_q     <= 1'b1;
      ce1u_q     <= 1'b1;
      oe_q       <= 1'b1;
      we_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      ras_prev_q <= ras_s;
      row_q      <= row_d;
      a_row_q    <= a_row_d;
      col_q      <= col_d;
      bank_q     <= bank_d;
      cas_seen_q <= cas_seen_d;
      we_cnt_q   <= we_cnt_d;
      ref_q      <= ref_d;
      err_q      <= err_d;
      ce2_q      <= ce2_d;
      ce1l_q     <= ce1l_d;
      ce1u_q     <= ce1u_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
    end
  end

  assign sram_a      = {bank_q, a_row_q, col_q};
  assign ce2         = ce2_q;
  assign ce1_l_n     = ce1l_q;
  assign ce1_u_n     = ce1u_q;
  assign oe_n        = oe_q;
  assign we_n        = we_q;
  assign refresh_cnt = ref_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_a1000_frontram_sync.sv
// Directed and randomized bus cycles for a1000_frontram_sync, checked against a
// transaction-level model of the expected SRAM address, strobes, refresh count and error flag.
module tb_a1000_frontram_sync;

  localparam int ROW_BITS    = 8;
  localparam int NUM_BANKS   = 2;
  localparam int WE_CYCLES   = 2;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 17;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ras_n, rrw_n;
  logic [NUM_BANKS-1:0] casl_n, casu_n;
  logic [ROW_BITS-1:0]  dra;
  logic [ADDR_W-1:0]    sram_a;
  logic                 ce2, ce1_l_n, ce1_u_n, oe_n, we_n, err;
  logic [15:0]          refresh_cnt;
  logic [2:0]           dbg_state;

  a1000_frontram_sync #(
    .ROW_BITS(ROW_BITS), .NUM_BANKS(NUM_BANKS),
    .WE_CYCLES(WE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .ras_n(ras_n), .rrw_n(rrw_n),
    .casl_n(casl_n), .casu_n(casu_n), .dra(dra),
    .sram_a(sram_a), .ce2(ce2), .ce1_l_n(ce1_l_n), .ce1_u_n(ce1_u_n),
    .oe_n(oe_n), .we_n(we_n), .refresh_cnt(refresh_cnt), .err(err),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [15:0]       exp_ref;
  logic              exp_err;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_idle();
    ras_n = 1'b1; rrw_n = 1'b1; casl_n = '1; casu_n = '1; dra = '0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ref"}, 32'(refresh_cnt), 32'(exp_ref));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_ce2"}, 32'(ce2), 32'd0);
  endtask

  // One RAS cycle carrying ncols CAS pulses (page mode when ncols > 1), each CAS low for len clocks.
  task automatic ras_cycle(input string tag, input logic [7:0] row, input logic [1:0] lmask,
                           input logic [1:0] umask, input bit wr, input int ncols,
                           input logic [7:0] col0, input int len, input bit ras_early);
    logic              bank;
    logic [ADDR_W-1:0] a;
    int                oe_low, we_low, we_exp;
    bit                last;
    bank = ((lmask | umask) & 2'b01) != 2'b00 ? 1'b0 : 1'b1;
    for (int k = 0; k < ncols; k++) exp_q.push_back({bank, row, col0 + 8'(k)});
    ras_n = 1'b0; dra = row; rrw_n = 1'b1;
    tick(2);
    for (int k = 0; k < ncols; k++) begin
      last = (k == ncols - 1);
      a = exp_q.pop_front();
      casl_n = ~lmask; casu_n = ~umask; dra = col0 + 8'(k); rrw_n = !wr;
      oe_low = 0; we_low = 0;
      for (int i = 1; i <= len + 3; i++) begin
        tick(1);
        if (i == 2) begin
          check({tag, "_lat_oe"}, 32'(oe_n), 32'd1);
          check({tag, "_lat_we"}, 32'(we_n), 32'd1);
        end
        if (i == 3) begin
          check({tag, "_addr"}, 32'(sram_a), 32'(a));
          check({tag, "_ce1l"}, 32'(ce1_l_n), 32'(~|lmask));
          check({tag, "_ce1u"}, 32'(ce1_u_n), 32'(~|umask));
        end
        if (i >= 3 && i <= len + 2) check({tag, "_ce2"}, 32'(ce2), 32'd1);
        if (!oe_n) oe_low++;
        if (!we_n) begin
          we_low++;
          check({tag, "_addr_we"}, 32'(sram_a), 32'(a));
        end
        if (i == 1 && last && ras_early) ras_n = 1'b1;
        if (i == len) begin
          casl_n = '1; casu_n = '1; dra = 8'($urandom_range(0, 255));
          if (last) ras_n = 1'b1;
        end
      end
      check({tag, "_ce2_end"}, 32'(ce2), last ? 32'd0 : 32'd1);
      check({tag, "_oe_end"}, 32'(oe_n), 32'd1);
      check({tag, "_we_end"}, 32'(we_n), 32'd1);
      we_exp = (len < WE_CYCLES) ? len : WE_CYCLES;
      check({tag, "_oe_width"}, 32'(oe_low), wr ? 32'd0 : 32'(len));
      check({tag, "_we_width"}, 32'(we_low), wr ? 32'(we_exp) : 32'd0);
      if (wr && len < WE_CYCLES) exp_err = 1'b1;
    end
    if ((lmask | umask) == 2'b11) exp_err = 1'b1;
    bus_idle();
    tick(2);
    check_idle(tag);
  endtask

  task automatic cbr(input string tag, input int hold);
    casl_n[0] = 1'b0; casu_n[0] = 1'b0;
    tick(2);
    ras_n = 1'b0;
    for (int i = 1; i <= hold + 4; i++) begin
      tick(1);
      check({tag, "_ce2"}, 32'(ce2), 32'd0);
      if (oe_n !== 1'b1 || we_n !== 1'b1) check({tag, "_strobes"}, {oe_n, we_n}, 32'd3);
      if (i == hold) bus_idle();
    end
    exp_ref = exp_ref + 16'd1;
    tick(2);
    check_idle(tag);
  endtask

  task automatic ras_only(input string tag, input logic [7:0] row, input int hold);
    ras_n = 1'b0; dra = row;
    for (int i = 1; i <= hold + 4; i++) begin
      tick(1);
      if (i == 3) check({tag, "_ce2_row"}, 32'(ce2), 32'd1);
      if (oe_n !== 1'b1 || we_n !== 1'b1) check({tag, "_strobes"}, {oe_n, we_n}, 32'd3);
      if (i == hold) bus_idle();
    end
    exp_ref = exp_ref + 16'd1;
    tick(2);
    check_idle(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] lm, um, lanes;
    int         kind, b, ncols, len;
    bit         early;

    // clock/reset
    rst = 1'b1; bus_idle();
    exp_ref = 16'd0; exp_err = 1'b0;
    tick(2);
    check("rst_addr", 32'(sram_a), 32'd0);
    check("rst_ce2", 32'(ce2), 32'd0);
    check("rst_ce1", {ce1_l_n, ce1_u_n}, 32'd3);
    check("rst_oe_we", {oe_n, we_n}, 32'd3);
    check("rst_ref", 32'(refresh_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(3);

    // directed cycles
    ras_cycle("read_b0", 8'h12, 2'b01, 2'b01, 1'b0, 1, 8'h34, 4, 1'b0);
    ras_cycle("write_b1u", 8'hAB, 2'b00, 2'b10, 1'b1, 1, 8'hCD, 4, 1'b0);
    ras_cycle("page", 8'h55, 2'b01, 2'b01, 1'b0, 3, 8'h00, 3, 1'b0);
    cbr("cbr", 3);
    check("cbr_count", 32'(refresh_cnt), 32'd1);
    ras_only("rasonly", 8'h3C, 4);
    check("rasonly_count", 32'(refresh_cnt), 32'd2);
    ras_cycle("read_rasearly", 8'h21, 2'b10, 2'b00, 1'b0, 1, 8'h43, 4, 1'b1);
    ras_cycle("multibank", 8'h66, 2'b11, 2'b00, 1'b0, 1, 8'h77, 3, 1'b0);
    check("multibank_err", 32'(err), 32'd1);

    // reset in the middle of a write pulse
    ras_n = 1'b0; dra = 8'h77;
    tick(2);
    casl_n[0] = 1'b0; dra = 8'h66; rrw_n = 1'b0;
    tick(3);
    check("midwr_we_low", 32'(we_n), 32'd0);
    rst = 1'b1;
    #1;
    check("midwr_we", 32'(we_n), 32'd1);
    check("midwr_addr", 32'(sram_a), 32'd0);
    check("midwr_ref", 32'(refresh_cnt), 32'd0);
    check("midwr_err", 32'(err), 32'd0);
    check("midwr_ce2", 32'(ce2), 32'd0);
    exp_ref = 16'd0; exp_err = 1'b0;
    bus_idle();
    tick(2);
    rst = 1'b0;
    tick(3);
    ras_cycle("post_rst", 8'h0F, 2'b01, 2'b01, 1'b1, 1, 8'hF0, 3, 1'b0);
    ras_cycle("short_wr", 8'h11, 2'b01, 2'b00, 1'b1, 1, 8'h22, 1, 1'b0);
    check("short_wr_err", 32'(err), 32'd1);

    // randomized cycles
    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 5);
      b = $urandom_range(0, 1);
      lanes = 2'($urandom_range(1, 3));
      lm = lanes[0] ? 2'(1 << b) : 2'b00;
      um = lanes[1] ? 2'(1 << b) : 2'b00;
      if ($urandom_range(0, 7) == 0) lm = 2'b11;
      ncols = $urandom_range(1, 3);
      len = $urandom_range(1, 5);
      early = (ncols == 1) && ($urandom_range(0, 1) == 1);
      case (kind)
        3: cbr("rnd_cbr", $urandom_range(1, 4));
        4: ras_only("rnd_rasonly", 8'($urandom_range(0, 255)), $urandom_range(1, 4));
        default: ras_cycle("rnd_cycle", 8'($urandom_range(0, 255)), lm, um, kind == 5, ncols,
                           8'($urandom_range(0, 252)), len, early);
      endcase
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
